// File: rtl/vram_scan_pkg.sv
// vram_scan_pkg
// Shared types for the VRAM scan checker: the controller state encoding,
// the expected-data mode, and the width of the drain counter.
package vram_scan_pkg;

    // Controller states: waiting, issuing addresses, waiting for the last
    // read data to come back, and holding the result.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_e;

    // Expected-data mode: a constant pattern, or the pattern XORed with the
    // address that produced the data.
    typedef enum logic {
        MODE_CONST = 1'b0,
        MODE_ADDR  = 1'b1
    } scan_mode_e;

    // Read latency is limited to 1..4, so a 3-bit counter always covers
    // the drain period.
    localparam int DRAIN_CNT_W = 3;

endpackage

// File: rtl/vram_scan_delay.sv
// vram_scan_delay
// LAT-deep delay line carrying a valid bit and an address.
// Its output lines up with read data returned LAT cycles after the address.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (clears all valid bits)
//   flush_i  in   drops every in-flight entry (valid bits cleared)
//   valid_i  in   an address is being issued this cycle
//   addr_i   in   issued address
//   valid_o  out  delayed valid
//   addr_o   out  delayed address
module vram_scan_delay
    import vram_scan_pkg::*;
#(
    parameter int LAT    = 1,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic              valid_q [LAT];
    logic [ADDR_W-1:0] addr_q  [LAT];

    // Stage 0 takes the freshly issued address; each later stage copies its
    // predecessor. Flushing clears only the valid bits, because a stale
    // address behind a cleared valid is never looked at.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                valid_q[i] <= 1'b0;
                addr_q[i]  <= '0;
            end
        end else begin
            if (flush_i) begin
                for (int i = 0; i < LAT; i++) begin
                    valid_q[i] <= 1'b0;
                end
            end else begin
                valid_q[0] <= valid_i;
                for (int i = 1; i < LAT; i++) begin
                    valid_q[i] <= valid_q[i-1];
                end
            end
            addr_q[0] <= addr_i;
            for (int i = 1; i < LAT; i++) begin
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[LAT-1];
    assign addr_o  = addr_q[LAT-1];

endmodule

// File: rtl/vram_scan_checker.sv
// vram_scan_checker
// Sweeps one shared read address from 0 up to the largest per-channel last
// address. It checks every channel's returned data against an expected
// value, either a constant pattern or the pattern XOR the address.
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   start          begin a scan (accepted only in IDLE or DONE)
//   abort          cancel a scan / clear a held result
//   mode           0 = constant pattern, 1 = pattern XOR address
//   pattern        expected-data seed, latched on accepted start
//   ch_last_addr   per-channel last valid address, latched on accepted start
//   rd_addr        shared read address to all channels
//   rd_data        per-channel read data, RD_LAT cycles after rd_addr
//   busy           scan or drain in progress
//   done           result is being held
//   pass           done with no mismatching channel
//   err_mask       sticky per-channel mismatch flags
//   fail_ch/addr/data  first mismatch of the scan (lowest channel on ties)
module vram_scan_checker
    import vram_scan_pkg::*;
#(
    parameter  int NUM_CH = 6,
    parameter  int ADDR_W = 12,
    parameter  int DATA_W = 64,
    parameter  int RD_LAT = 1,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     mode,
    input  logic [DATA_W-1:0]        pattern,
    input  logic [NUM_CH*ADDR_W-1:0] ch_last_addr,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic [NUM_CH*DATA_W-1:0] rd_data,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [NUM_CH-1:0]        err_mask,
    output logic [CH_W-1:0]          fail_ch,
    output logic [ADDR_W-1:0]        fail_addr,
    output logic [DATA_W-1:0]        fail_data
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(RD_LAT - 1);

    scan_state_e             state_q, state_d;
    logic [ADDR_W-1:0]       rdAddr_q, rdAddr_d;
    logic [DRAIN_CNT_W-1:0]  drainCnt_q, drainCnt_d;
    logic [ADDR_W-1:0]       maxLast_q;
    logic [ADDR_W-1:0]       maxLastIn;
    scan_mode_e              mode_q;
    logic [DATA_W-1:0]       pattern_q;
    logic [ADDR_W-1:0]       lastAddr_q [NUM_CH];
    logic [NUM_CH-1:0]       errMask_q;
    logic [CH_W-1:0]         failCh_q;
    logic [ADDR_W-1:0]       failAddr_q;
    logic [DATA_W-1:0]       failData_q;

    logic                    idleOrDone;
    logic                    scanActive;
    logic                    acceptStart;
    logic                    flush;
    logic                    dlyValid;
    logic [ADDR_W-1:0]       dlyAddr;
    logic [DATA_W-1:0]       dlyAddrExt;
    logic [DATA_W-1:0]       expData;
    logic [NUM_CH-1:0]       mismatch;
    logic [CH_W-1:0]         firstCh;
    logic [DATA_W-1:0]       firstData;

    assign idleOrDone  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign scanActive  = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
    // Abort has priority over a start arriving in the same cycle.
    assign acceptStart = start && !abort && idleOrDone;
    assign flush       = abort && scanActive;

    // Scan length is set by the furthest channel; shorter channels simply
    // stop comparing once the address passes their own last address.
    always_comb begin
        maxLastIn = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_last_addr[i*ADDR_W +: ADDR_W] > maxLastIn) begin
                maxLastIn = ch_last_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // State, address and drain counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rdAddr_q   <= '0;
            drainCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rdAddr_q   <= rdAddr_d;
            drainCnt_q <= drainCnt_d;
        end
    end

    // Next-state logic. The address stops at maxLast rather than wrapping,
    // so an all-ones last address ends the scan at all-ones.
    always_comb begin
        state_d    = state_q;
        rdAddr_d   = rdAddr_q;
        drainCnt_d = drainCnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d  = ST_SCAN;
                    rdAddr_d = '0;
                end
            end
            ST_SCAN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (rdAddr_q == maxLast_q) begin
                    state_d    = ST_DRAIN;
                    drainCnt_d = '0;
                end else begin
                    rdAddr_d = rdAddr_q + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (drainCnt_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    drainCnt_d = drainCnt_q + DRAIN_CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Only SCAN cycles issue an address into the read pipeline.
    vram_scan_delay #(
        .LAT    (RD_LAT),
        .ADDR_W (ADDR_W)
    ) u_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .valid_i (state_q == ST_SCAN),
        .addr_i  (rdAddr_q),
        .valid_o (dlyValid),
        .addr_o  (dlyAddr)
    );

    // Expected data is derived from the delayed address, i.e. the address
    // that actually produced the data arriving now.
    always_comb begin
        dlyAddrExt                = '0;
        dlyAddrExt[ADDR_W-1:0]    = dlyAddr;
        expData = (mode_q == MODE_ADDR) ? (pattern_q ^ dlyAddrExt) : pattern_q;
    end

    // Per-channel mismatch, plus the lowest failing channel of this cycle.
    always_comb begin
        mismatch  = '0;
        firstCh   = '0;
        firstData = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mismatch[i] = dlyValid && (dlyAddr <= lastAddr_q[i]) &&
                          (rd_data[i*DATA_W +: DATA_W] != expData);
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mismatch[i]) begin
                firstCh   = CH_W'(i);
                firstData = rd_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Scan configuration and results. An empty error mask means no
    // mismatch has been seen yet this scan, so it doubles as the
    // "first failure still free" flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            maxLast_q   <= '0;
            mode_q      <= MODE_CONST;
            pattern_q   <= '0;
            errMask_q   <= '0;
            failCh_q    <= '0;
            failAddr_q  <= '0;
            failData_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                lastAddr_q[i] <= '0;
            end
        end else if (acceptStart) begin
            maxLast_q   <= maxLastIn;
            mode_q      <= scan_mode_e'(mode);
            pattern_q   <= pattern;
            errMask_q   <= '0;
            failCh_q    <= '0;
            failAddr_q  <= '0;
            failData_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                lastAddr_q[i] <= ch_last_addr[i*ADDR_W +: ADDR_W];
            end
        end else begin
            errMask_q <= errMask_q | mismatch;
            if ((errMask_q == '0) && (|mismatch)) begin
                failCh_q   <= firstCh;
                failAddr_q <= dlyAddr;
                failData_q <= firstData;
            end
        end
    end

    assign rd_addr   = rdAddr_q;
    assign busy      = scanActive;
    assign done      = (state_q == ST_DONE);
    assign pass      = done && (errMask_q == '0);
    assign err_mask  = errMask_q;
    assign fail_ch   = failCh_q;
    assign fail_addr = failAddr_q;
    assign fail_data = failData_q;

endmodule

// File: tb/tb_vram_scan_checker.sv
// tb_vram_scan_checker
// Drives the scan checker against a latency-accurate memory model and
// compares its results with a reference computed directly from the memory
// contents, the per-channel last addresses and the expected-data rule.
module tb_vram_scan_checker;
    import vram_scan_pkg::*;

    localparam int NCH = 6;
    localparam int AW  = 12;
    localparam int DW  = 64;
    localparam int LAT = 3;
    localparam int DEPTH = 1 << AW;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic                abort;
    logic                mode;
    logic [DW-1:0]       pattern;
    logic [NCH*AW-1:0]   ch_last_addr;
    logic [AW-1:0]       rd_addr;
    logic [NCH*DW-1:0]   rd_data;
    logic                busy;
    logic                done;
    logic                pass;
    logic [NCH-1:0]      err_mask;
    logic [2:0]          fail_ch;
    logic [AW-1:0]       fail_addr;
    logic [DW-1:0]       fail_data;

    vram_scan_checker #(
        .NUM_CH (NCH),
        .ADDR_W (AW),
        .DATA_W (DW),
        .RD_LAT (LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .mode         (mode),
        .pattern      (pattern),
        .ch_last_addr (ch_last_addr),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .err_mask     (err_mask),
        .fail_ch      (fail_ch),
        .fail_addr    (fail_addr),
        .fail_data    (fail_data)
    );

    always #5 clk = ~clk;

    // Memory model: each channel returns mem[ch][addr] exactly LAT cycles
    // after the address was presented.
    logic [DW-1:0] mem [NCH][DEPTH];
    logic [AW-1:0] pipe [LAT];

    always @(posedge clk) begin
        pipe[0] <= rd_addr;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    for (genvar c = 0; c < NCH; c++) begin : g_rd
        assign rd_data[c*DW +: DW] = mem[c][pipe[LAT-1]];
    end

    int vectors     = 0;
    int miscompares = 0;
    int lastArr [NCH];
    int n;

    logic [NCH-1:0] expMask;
    logic           expAny;
    int             expCh;
    int             expAddr;
    logic [DW-1:0]  expData;
    int             expMax;

    function automatic logic [DW-1:0] expVal(input logic m, input logic [DW-1:0] pat, input int a);
        return m ? (pat ^ DW'(a)) : pat;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fillMem(input logic m, input logic [DW-1:0] pat);
        for (int c = 0; c < NCH; c++)
            for (int a = 0; a < DEPTH; a++)
                mem[c][a] = expVal(m, pat, a);
    endtask

    // Reference: walk addresses in issue order and channels in index order;
    // the first hit is the captured failure.
    task automatic computeModel(input logic m, input logic [DW-1:0] pat);
        expMask = '0; expAny = 1'b0; expCh = 0; expAddr = 0; expData = '0; expMax = 0;
        for (int c = 0; c < NCH; c++)
            if (lastArr[c] > expMax) expMax = lastArr[c];
        for (int a = 0; a <= expMax; a++) begin
            for (int c = 0; c < NCH; c++) begin
                if (a <= lastArr[c] && mem[c][a] !== expVal(m, pat, a)) begin
                    expMask[c] = 1'b1;
                    if (!expAny) begin
                        expAny = 1'b1; expCh = c; expAddr = a; expData = mem[c][a];
                    end
                end
            end
        end
    endtask

    task automatic driveLasts();
        for (int c = 0; c < NCH; c++) ch_last_addr[c*AW +: AW] = AW'(lastArr[c]);
    endtask

    // Runs one full scan from a start pulse and checks timing and result.
    task automatic applyStimulus(input string name, input logic m, input logic [DW-1:0] pat);
        int cyc;
        int busyCnt;
        computeModel(m, pat);
        @(negedge clk);
        mode = m; pattern = pat; driveLasts(); start = 1'b1;
        cyc = 0; busyCnt = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (busy) busyCnt++;
        end while (!done && cyc < 6000);
        checkOutput({name, " done"},      64'(done),      64'd1);
        checkOutput({name, " cycles"},    64'(cyc),       64'(expMax + LAT + 2));
        checkOutput({name, " busy_cyc"},  64'(busyCnt),   64'(expMax + LAT + 1));
        checkOutput({name, " rd_addr"},   64'(rd_addr),   64'(expMax));
        checkOutput({name, " err_mask"},  64'(err_mask),  64'(expMask));
        checkOutput({name, " pass"},      64'(pass),      64'(!expAny));
        checkOutput({name, " fail_ch"},   64'(fail_ch),   64'(expCh));
        checkOutput({name, " fail_addr"}, 64'(fail_addr), 64'(expAddr));
        checkOutput({name, " fail_data"}, 64'(fail_data), expData);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, " rd_addr"},   64'(rd_addr),   64'd0);
        checkOutput({name, " busy"},      64'(busy),      64'd0);
        checkOutput({name, " done"},      64'(done),      64'd0);
        checkOutput({name, " pass"},      64'(pass),      64'd0);
        checkOutput({name, " err_mask"},  64'(err_mask),  64'd0);
        checkOutput({name, " fail_ch"},   64'(fail_ch),   64'd0);
        checkOutput({name, " fail_addr"}, 64'(fail_addr), 64'd0);
        checkOutput({name, " fail_data"}, fail_data,      64'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0;
        pattern = '0; ch_last_addr = '0;
        for (int i = 0; i < LAT; i++) pipe[i] = '0;
        #12;
        checkAllZero("reset");
        @(negedge clk); rst_n = 1'b1;

        // Full clean constant-pattern scan, then a single corrupted word.
        for (int c = 0; c < NCH; c++) lastArr[c] = 2047;
        fillMem(1'b0, 64'd12345);
        applyStimulus("const_clean", 1'b0, 64'd12345);

        // Abort while holding a result clears done.
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checkOutput("abort_done done", 64'(done), 64'd0);
        checkOutput("abort_done pass", 64'(pass), 64'd0);

        mem[3][100] = '0;
        applyStimulus("const_ch3", 1'b0, 64'd12345);

        // Address mode with unequal last addresses, including all-ones.
        lastArr = '{0, 2047, 4095, 39, 39, 39};
        fillMem(1'b1, 64'hFF00);
        applyStimulus("addr_clean", 1'b1, 64'hFF00);
        mem[0][1] = mem[0][1] ^ 64'hDEAD;
        applyStimulus("addr_beyond", 1'b1, 64'hFF00);

        // Two channels failing on the same address, plus a later failure.
        for (int c = 0; c < NCH; c++) lastArr[c] = 100;
        fillMem(1'b1, 64'h1234_5678_9ABC_DEF0);
        mem[1][7]  = mem[1][7]  ^ 64'h11;
        mem[4][7]  = mem[4][7]  ^ 64'h4400;
        mem[0][20] = mem[0][20] ^ 64'h1;
        applyStimulus("tie", 1'b1, 64'h1234_5678_9ABC_DEF0);

        // Start during a scan is ignored; abort beats a simultaneous start.
        for (int c = 0; c < NCH; c++) lastArr[c] = 200;
        fillMem(1'b0, 64'hA5A5_5A5A_0F0F_F0F0);
        @(negedge clk);
        mode = 1'b0; pattern = 64'hA5A5_5A5A_0F0F_F0F0; driveLasts(); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (rd_addr != 12'd20 && n < 1000) begin @(negedge clk); n++; end
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        checkOutput("ignored_start rd_addr", 64'(rd_addr), 64'd21);
        checkOutput("ignored_start busy",    64'(busy),    64'd1);
        n = 0;
        while (rd_addr != 12'd50 && n < 1000) begin @(negedge clk); n++; end
        abort = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        checkOutput("abort idle busy", 64'(busy), 64'd0);
        applyStimulus("after_abort", 1'b0, 64'hA5A5_5A5A_0F0F_F0F0);

        // One-address scan.
        for (int c = 0; c < NCH; c++) lastArr[c] = 0;
        applyStimulus("single", 1'b0, 64'hA5A5_5A5A_0F0F_F0F0);

        // Reset in the middle of a failing scan.
        for (int c = 0; c < NCH; c++) lastArr[c] = 100;
        fillMem(1'b1, 64'h0BAD_F00D);
        mem[2][3] = mem[2][3] ^ 64'h1;
        @(negedge clk);
        mode = 1'b1; pattern = 64'h0BAD_F00D; driveLasts(); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("pre_reset err_mask", 64'(err_mask), 64'h04);
        rst_n = 1'b0;
        #1;
        checkAllZero("mid_reset");
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("post_reset busy", 64'(busy), 64'd0);
        checkOutput("post_reset done", 64'(done), 64'd0);

        // Randomized scans with a few corrupted words each.
        for (int t = 0; t < 10; t++) begin
            logic          m;
            logic [DW-1:0] pat;
            int            k;
            m   = 1'($urandom_range(0, 1));
            pat = {$urandom, $urandom};
            for (int c = 0; c < NCH; c++) lastArr[c] = $urandom_range(0, 255);
            fillMem(m, pat);
            k = $urandom_range(0, 3);
            for (int j = 0; j < k; j++) begin
                int c2;
                int a2;
                c2 = $urandom_range(0, NCH - 1);
                a2 = $urandom_range(0, 300);
                mem[c2][a2] = mem[c2][a2] ^ ({$urandom, $urandom} | 64'h1);
            end
            applyStimulus($sformatf("rand%0d", t), m, pat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vram_scan_checker.md
VRAM_SCAN_CHECKER -- requirements
Module: vram_scan_checker

Interface
REQ-001 SHALL have parameter NUM_CH, default 6, number of independent VRAM read channels checked in parallel.
REQ-002 SHALL have parameter ADDR_W, default 12, width of the shared scan address.
REQ-003 SHALL have parameter DATA_W, default 64, width of each channel's read data.
REQ-004 SHALL have parameter RD_LAT, default 1, cycles from rd_addr to valid rd_data (range 1..4).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  one-cycle request to begin a scan; honoured only in IDLE or DONE.
REQ-008 abort  in  1  cancel an active scan.
REQ-009 mode  in  1  0 = CONST (expected = pattern), 1 = ADDR (expected = pattern XOR zero-extended address).
REQ-010 pattern  in  DATA_W  expected-data seed; sampled on accepted start.
REQ-011 ch_last_addr  in  NUM_CH*ADDR_W  per-channel last valid address; sampled on accepted start.
REQ-012 rd_addr  out  ADDR_W  shared read address driven to all channels.
REQ-013 rd_data  in  NUM_CH*DATA_W  per-channel read data, channel i at slice i.
REQ-014 busy  out  1  high in SCAN and DRAIN.
REQ-015 done  out  1  high in DONE until next accepted start or abort.
REQ-016 pass  out  1  done AND err_mask all zero.
REQ-017 err_mask  out  NUM_CH  sticky per-channel mismatch flags.
REQ-018 fail_ch / fail_addr / fail_data  out  $clog2(NUM_CH) / ADDR_W / DATA_W  first mismatch captured.

Function
REQ-019 FSM SHALL have states IDLE, SCAN, DRAIN, DONE.
REQ-020 Accepted start SHALL clear err_mask and fail_* to 0, latch pattern/mode/ch_last_addr, register max_last = maximum of ch_last_addr, set rd_addr = 0, enter SCAN next cycle.
REQ-021 In SCAN rd_addr SHALL increment by 1 per cycle; on the cycle rd_addr == max_last, next state is DRAIN and rd_addr holds.
REQ-022 DRAIN SHALL last exactly RD_LAT cycles, then enter DONE; no new addresses issued.
REQ-023 Each issued address SHALL propagate through an RD_LAT-deep valid/address delay line; compare occurs when the delayed valid is high.
REQ-024 Channel i SHALL compare only when delayed address <= latched ch_last_addr[i]; beyond it the channel is ignored.
REQ-025 A mismatch on channel i SHALL set err_mask[i] the following cycle and keep it set until next accepted start.
REQ-026 fail_* SHALL capture only the first mismatching compare cycle of a scan; if several channels fail that cycle, the lowest index is captured.
REQ-027 ADDR mode expected value SHALL use the delayed (not current) address.
REQ-028 max_last = 0 SHALL yield a one-address scan: SCAN 1 cycle, DRAIN RD_LAT cycles.
REQ-029 rd_addr SHALL never wrap; max_last = 2^ADDR_W-1 terminates at all-ones.
REQ-030 start during SCAN or DRAIN SHALL be ignored.
REQ-031 abort in SCAN or DRAIN SHALL go to IDLE next cycle, flush the delay line, keep err_mask/fail_*, leave done low; abort wins over simultaneous start.
REQ-032 abort in IDLE or DONE SHALL clear done and go to IDLE.

Reset
REQ-033 On rst_n low: state IDLE, rd_addr 0, busy 0, done 0, pass 0, err_mask 0, fail_* 0, delay line valids 0.
REQ-034 Reset asserted mid-scan SHALL abandon the scan with no result.

Structure
REQ-035 Package vram_scan_pkg SHALL hold the state enum and mode enum (MODE_CONST, MODE_ADDR).
REQ-036 Sub-module vram_scan_delay SHALL implement the parameterised RD_LAT valid/address delay line with flush.

Verification
REQ-039 NUM_CH=6, all last=2047, CONST, pattern=12345, memories all 12345 -> done after 2048+RD_LAT+1 cycles from start, pass=1, err_mask=0.
REQ-040 Same, channel 3 address 100 = 0 -> err_mask=6'b001000, fail_ch=3, fail_addr=100, fail_data=0, pass=0.
REQ-041 ADDR mode, pattern=0xFF00, memories hold 0xFF00^addr, last = {0,2047,4095,39,39,39} -> pass=1; corrupt channel 0 address 1 -> no error (beyond last).
REQ-042 Channels 1 and 4 fail same address 7 -> fail_ch=1, err_mask bits 1 and 4 set.
REQ-043 abort at rd_addr=50 with simultaneous start -> IDLE next cycle, busy=0, done=0; later start runs clean scan.
REQ-044 RD_LAT=3, last all 0 -> busy exactly 4 cycles, done on 5th, rst_n pulsed mid-scan -> all outputs 0.
